// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default data/address geometry and the read-scheduler state type.
// Imported by the read scheduler and the other FIFO blocks; holds no logic.
package fifo_pkg;

  localparam int DSIZE_DEF    = 8;
  localparam int ADDRSIZE_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  int            j;
  logic [IW-1:0] sel;

  // Scan from the farthest offset down so the nearest set request is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      sel = IW'(j);
      if (req[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Round-robin FIFO read scheduler: grants one of NREQ readers, pops up to BURST_LEN words per grant (FIFO_RD_SCHED_BURST_EN, else 1).
// rinc is combinational, dout/dvalid follow a pop by 1 cycle; an empty FIFO stalls the burst, a dropped owner request ends it.
module fifo_rd_sched
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [NREQ-1:0]  req,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [NREQ-1:0]  gnt,
  output logic [DSIZE-1:0] dout,
  output logic [NREQ-1:0]  dvalid,
  output logic             busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_LEN) + 1;
`ifdef FIFO_RD_SCHED_BURST_EN
  localparam int BL = BURST_LEN;
`else
  localparam int BL = 1;
`endif
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  rd_state_t       state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            own_req;
  logic            last_pop;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req  = req[owner_q];
  // Reset gates the strobe so no word leaves the FIFO while state is being cleared.
  assign rinc     = (state_q == BURST) & own_req & ~rempty & ~rrst;
  assign last_pop = rinc & (bcnt_q == CW'(BL - 1));
  assign busy     = (state_q == BURST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    bcnt_d   = bcnt_q;
    gnt_d    = gnt;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found && !rempty) begin
          state_d = BURST;
          owner_d = pick_idx;
          gnt_d   = ONE << pick_idx;
          bcnt_d  = '0;
        end
      end
      BURST: begin
        if (rinc) bcnt_d = bcnt_q + 1'b1;
        if (last_pop || !own_req) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      bcnt_q   <= '0;
      gnt      <= '0;
      dout     <= '0;
      dvalid   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      bcnt_q   <= bcnt_d;
      gnt      <= gnt_d;
      dvalid   <= rinc ? (ONE << owner_q) : '0;
      if (rinc) dout <= rdata;
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Randomised scoreboard bench for fifo_rd_sched against a transaction-level arbitration model.
module tb_fifo_rd_sched;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int BURST_LEN = 4;
`ifdef FIFO_RD_SCHED_BURST_EN
  localparam int BL = BURST_LEN;
`else
  localparam int BL = 1;
`endif

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic [DSIZE-1:0] dout;
  logic [NREQ-1:0]  dvalid;
  logic             busy;

  fifo_rd_sched #(
    .DSIZE     (DSIZE),
    .NREQ      (NREQ),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .req    (req),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .gnt    (gnt),
    .dout   (dout),
    .dvalid (dvalid),
    .busy   (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [NREQ-1:0]  who;
    logic [DSIZE-1:0] data;
  } exp_t;

  int               total = 0;
  int               bad   = 0;
  exp_t             sb[$];
  exp_t             mon_e;
  logic [DSIZE-1:0] fifo_q[$];
  int               m_owner = -1;  // -1: nobody holds the read port
  int               m_next  = 0;   // requester that wins ties at the next arbitration
  int               m_cnt   = 0;   // words delivered in the current grant
  bit               prev_rst = 1'b1;
  logic [NREQ-1:0]  r_rand = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    if (i < 0) return '0;
    return NREQ'(1) << i;
  endfunction

  // Output monitor: every delivered word must match the oldest predicted pop.
  always @(negedge rclk) begin
    if (dvalid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_dvalid", 32'(dvalid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("dvalid_owner", 32'(dvalid), 32'(mon_e.who));
        check("dout", 32'(dout), 32'(mon_e.data));
      end
    end
  end

  task automatic cycle(input logic [NREQ-1:0] r, input bit emp, input bit rst);
    bit exp_rinc;
    bit got;
    int idx;
    @(negedge rclk);
    check("gnt", 32'(gnt), 32'(onehot(m_owner)));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    if (prev_rst) begin
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_dvalid", 32'(dvalid), 32'd0);
    end
    if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) fifo_q.push_back(DSIZE'($urandom));
    req    = r;
    rrst   = rst;
    rempty = emp || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : DSIZE'($urandom);
    #1;
    exp_rinc = !rst && (m_owner >= 0) && r[m_owner] && !rempty;
    check("rinc", 32'(rinc), 32'(exp_rinc));
    if (exp_rinc) sb.push_back('{onehot(m_owner), fifo_q[0]});
    @(posedge rclk);
    prev_rst = rst;
    if (rst) begin
      m_owner = -1;
      m_next  = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      if (r != '0 && !rempty) begin
        got = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_next + k) % NREQ;
          if (!got && r[idx]) begin
            m_owner = idx;
            got     = 1'b1;
          end
        end
        m_cnt = 0;
      end
    end else begin
      if (exp_rinc) begin
        fifo_q.delete(0);
        m_cnt++;
      end
      if ((exp_rinc && m_cnt == BL) || !r[m_owner]) begin
        m_next  = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge rclk);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0);
    // Single requester streaming, then all four competing.
    for (int i = 0; i < 40; i++) cycle(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) cycle(4'b1111, 1'b0, 1'b0);
    // Requester 2 alone with empty windows mid-burst.
    for (int i = 0; i < 60; i++) cycle(4'b0100, (i % 12) >= 6, 1'b0);
    // Random level-held requests, empty stalls and occasional mid-run resets.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 7) == 0) r_rand[b] = ~r_rand[b];
      cycle(r_rand, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    cycle(4'b1010, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b0);
    @(negedge rclk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
